// File: rtl/pid_const_bank_if.sv
// Tuning bus between the button/debounce front end, the constant bank and the PID/display consumers.
// Optional PID_CONST_COMMIT_EN adds the commit strobe.
interface pid_const_bank_if #(
    parameter int WIDTH  = 13,
    parameter int NUM_CH = 5,
    parameter int CH_W   = 3
);
    logic                    inc_const;
    logic                    dec_const;
    logic [CH_W-1:0]         choose_c;
    logic [1:0]              choose;
`ifdef PID_CONST_COMMIT_EN
    logic                    commit;
`endif
    logic [NUM_CH*WIDTH-1:0] k_i;
    logic [NUM_CH*WIDTH-1:0] k_p;
    logic [NUM_CH*WIDTH-1:0] target_v;
    logic [WIDTH-1:0]        cur_val;
    logic                    sat;

    modport master (
        output inc_const, dec_const, choose_c, choose,
`ifdef PID_CONST_COMMIT_EN
        output commit,
`endif
        input  k_i, k_p, target_v, cur_val, sat
    );

    modport slave (
        input  inc_const, dec_const, choose_c, choose,
`ifdef PID_CONST_COMMIT_EN
        input  commit,
`endif
        output k_i, k_p, target_v, cur_val, sat
    );
endinterface

// File: rtl/pid_const_bank.sv
// Run-time k_i/k_p/target_v bank for NUM_CH PID rails, stepped by held inc/dec buttons with auto-repeat.
// Optional PID_CONST_COMMIT_EN: steps edit shadow copies that are copied to the live outputs on commit.
//
// state      | meaning
// S_IDLE     | waiting for a single-button press (a release must have been seen since reset)
// S_HOLD     | first step taken, timing the auto-repeat delay
// S_REPEAT   | auto-repeating; step size switches to FAST_STEP after FAST_CNT steps
// S_WAIT_REL | hold aborted, ignoring buttons until both are released
module pid_const_bank #(
    parameter int WIDTH  = 13,
    parameter int NUM_CH = 5,
    parameter int CH_W   = 3,
    parameter logic [NUM_CH*WIDTH-1:0] INIT_KI = {13'd32, 13'd4, 13'd32, 13'd32, 13'd45},
    parameter logic [NUM_CH*WIDTH-1:0] INIT_KP = {13'd16, 13'd4, 13'd32, 13'd16, 13'd14},
    parameter logic [NUM_CH*WIDTH-1:0] INIT_TV = {13'd2048, 13'd2080, 13'd2158, 13'd2048, 13'd2057},
    parameter int REPEAT_DLY = 1000000,
    parameter int REPEAT_PER = 100000,
    parameter int FAST_CNT   = 8,
    parameter int FAST_STEP  = 16
) (
    input  logic            clk,
    input  logic            rst,
    pid_const_bank_if.slave bus
);
    localparam int CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int REP_W   = (FAST_CNT < 1) ? 1 : $clog2(FAST_CNT + 1);
    localparam logic [CNT_W-1:0] DLY_LD    = CNT_W'(REPEAT_DLY - 1);
    localparam logic [CNT_W-1:0] PER_LD    = CNT_W'(REPEAT_PER - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [REP_W-1:0] REP_ONE   = REP_W'(1);
    localparam logic [REP_W-1:0] REP_FAST  = REP_W'(FAST_CNT);
    localparam logic [WIDTH-1:0] STEP_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] STEP_FAST = WIDTH'(FAST_STEP);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT, S_WAIT_REL} state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [REP_W-1:0]  r_rep, w_rep_nxt;
    logic              r_inc, r_dec, r_armed, r_dir_inc;
    logic [CH_W-1:0]   r_ch, r_sel_ch;
    logic [1:0]        r_fld, r_sel_fld;
    logic [WIDTH-1:0]  r_ki [NUM_CH];
    logic [WIDTH-1:0]  r_kp [NUM_CH];
    logic [WIDTH-1:0]  r_tv [NUM_CH];
    logic [WIDTH-1:0]  r_cur;
    logic              r_sat;

    logic              w_press, w_rel, w_abort, w_step_en, w_big, w_latch;
    logic              w_dir, w_hit, w_clip;
    logic [WIDTH-1:0]  w_old, w_step, w_new;
    logic [WIDTH:0]    w_sum;
    logic [NUM_CH*WIDTH-1:0] w_ki_pk, w_kp_pk, w_tv_pk;

    // Armed only after both buttons were seen released, so a button held through reset never steps.
    assign w_press = r_armed && (r_inc ^ r_dec);
    assign w_rel   = !r_inc && !r_dec;
    assign w_abort = (r_inc && r_dec) || (r_dir_inc ? r_dec : r_inc) ||
                     (r_ch != r_sel_ch) || (r_fld != r_sel_fld);
    assign w_big   = (r_state != S_IDLE) && (r_rep >= REP_FAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rep     <= '0;
            r_inc     <= 1'b0;
            r_dec     <= 1'b0;
            r_ch      <= '0;
            r_fld     <= '0;
            r_armed   <= 1'b0;
            r_dir_inc <= 1'b0;
            r_sel_ch  <= '0;
            r_sel_fld <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rep   <= w_rep_nxt;
            r_inc   <= bus.inc_const;
            r_dec   <= bus.dec_const;
            r_ch    <= bus.choose_c;
            r_fld   <= bus.choose;
            if (!bus.inc_const && !bus.dec_const) r_armed <= 1'b1;
            if (w_latch) begin
                r_dir_inc <= r_inc;
                r_sel_ch  <= r_ch;
                r_sel_fld <= r_fld;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rep_nxt   = r_rep;
        w_step_en   = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_press) begin
                    w_step_en   = 1'b1;
                    w_latch     = 1'b1;
                    w_cnt_nxt   = DLY_LD;
                    w_rep_nxt   = '0;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD, S_REPEAT: begin
                if (w_rel || w_abort) begin
                    w_cnt_nxt   = '0;
                    w_rep_nxt   = '0;
                    w_state_nxt = w_rel ? S_IDLE : S_WAIT_REL;
                end else if (r_cnt == '0) begin
                    w_step_en   = 1'b1;
                    w_cnt_nxt   = PER_LD;
                    w_rep_nxt   = w_big ? r_rep : r_rep + REP_ONE;
                    w_state_nxt = S_REPEAT;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            S_WAIT_REL: begin
                if (w_rel) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_old = '0;
        w_hit = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_ch == CH_W'(c)) begin
                w_hit = 1'b1;
                case (r_fld)
                    2'd0:    w_old = r_ki[c];
                    2'd1:    w_old = r_kp[c];
                    default: w_old = r_tv[c];
                endcase
            end
        end
        w_dir  = (r_state == S_IDLE) ? r_inc : r_dir_inc;
        w_step = w_big ? STEP_FAST : STEP_ONE;
        w_sum  = {1'b0, w_old} + {1'b0, w_step};
        if (w_dir) begin
            w_clip = w_sum[WIDTH];
            w_new  = w_clip ? '1 : w_sum[WIDTH-1:0];
        end else begin
            w_clip = (w_step > w_old);
            w_new  = w_clip ? '0 : w_old - w_step;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_ki[c] <= INIT_KI[c*WIDTH +: WIDTH];
                r_kp[c] <= INIT_KP[c*WIDTH +: WIDTH];
                r_tv[c] <= INIT_TV[c*WIDTH +: WIDTH];
            end
            r_cur <= '0;
            r_sat <= 1'b0;
        end else begin
            r_sat <= 1'b0;
            if (w_step_en && w_hit) begin
                r_sat <= w_clip;
                for (int c = 0; c < NUM_CH; c++) begin
                    if (r_ch == CH_W'(c)) begin
                        case (r_fld)
                            2'd0:    r_ki[c] <= w_new;
                            2'd1:    r_kp[c] <= w_new;
                            default: r_tv[c] <= w_new;
                        endcase
                    end
                end
            end
            r_cur <= w_old;
        end
    end

`ifdef PID_CONST_COMMIT_EN
    logic [WIDTH-1:0] r_ki_live [NUM_CH];
    logic [WIDTH-1:0] r_kp_live [NUM_CH];
    logic [WIDTH-1:0] r_tv_live [NUM_CH];

    // Same-edge copy takes the shadow value from before any simultaneous step.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_ki_live[c] <= INIT_KI[c*WIDTH +: WIDTH];
                r_kp_live[c] <= INIT_KP[c*WIDTH +: WIDTH];
                r_tv_live[c] <= INIT_TV[c*WIDTH +: WIDTH];
            end
        end else if (bus.commit) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_ki_live[c] <= r_ki[c];
                r_kp_live[c] <= r_kp[c];
                r_tv_live[c] <= r_tv[c];
            end
        end
    end
`endif

    always_comb begin
        w_ki_pk = '0;
        w_kp_pk = '0;
        w_tv_pk = '0;
        for (int c = 0; c < NUM_CH; c++) begin
`ifdef PID_CONST_COMMIT_EN
            w_ki_pk[c*WIDTH +: WIDTH] = r_ki_live[c];
            w_kp_pk[c*WIDTH +: WIDTH] = r_kp_live[c];
            w_tv_pk[c*WIDTH +: WIDTH] = r_tv_live[c];
`else
            w_ki_pk[c*WIDTH +: WIDTH] = r_ki[c];
            w_kp_pk[c*WIDTH +: WIDTH] = r_kp[c];
            w_tv_pk[c*WIDTH +: WIDTH] = r_tv[c];
`endif
        end
    end

    assign bus.k_i      = w_ki_pk;
    assign bus.k_p      = w_kp_pk;
    assign bus.target_v = w_tv_pk;
    assign bus.cur_val  = r_cur;
    assign bus.sat      = r_sat;
endmodule

// File: tb/tb_pid_const_bank.sv
// Directed bench for pid_const_bank with short repeat timing (DLY=4, PER=2, FAST_CNT=3, FAST_STEP=16).
module tb_pid_const_bank;
    localparam int WIDTH  = 13;
    localparam int NUM_CH = 5;
    localparam int CH_W   = 3;
    localparam int DLY    = 4;
    localparam int PER    = 2;
    localparam int FC     = 3;
    localparam int FSTEP  = 16;
    localparam logic [64:0] INIT_KI = {13'd32, 13'd4, 13'd32, 13'd32, 13'd45};
    localparam logic [64:0] INIT_KP = {13'd16, 13'd4, 13'd32, 13'd16, 13'd14};
    localparam logic [64:0] INIT_TV = {13'd2048, 13'd2080, 13'd2158, 13'd2048, 13'd2057};

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [64:0] exp_ki, exp_kp, exp_tv;

    always #5 clk = ~clk;

    pid_const_bank_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .CH_W(CH_W)) bus ();

    pid_const_bank #(
        .WIDTH(WIDTH), .NUM_CH(NUM_CH), .CH_W(CH_W),
        .INIT_KI(INIT_KI), .INIT_KP(INIT_KP), .INIT_TV(INIT_TV),
        .REPEAT_DLY(DLY), .REPEAT_PER(PER), .FAST_CNT(FC), .FAST_STEP(FSTEP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int field(input logic [64:0] v, input int ch);
        logic [WIDTH-1:0] f;
        f = v[ch*WIDTH +: WIDTH];
        return int'(f);
    endfunction

    // Step size applied k cycles after the press step (0 when no step at k).
    function automatic int step_amt(input int k);
        int n;
        if (k == 0) return 1;
        if (k < DLY) return 0;
        if (((k - DLY) % PER) != 0) return 0;
        n = 1 + (k - DLY) / PER;
        return (n <= FC) ? 1 : FSTEP;
    endfunction

    function automatic int hold_sum(input int last_k);
        int s = 0;
        for (int k = 0; k <= last_k; k++) s += step_amt(k);
        return s;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int last;
        int ev;
        rst = 1'b1;
        bus.inc_const = 1'b0;
        bus.dec_const = 1'b0;
        bus.choose_c  = 3'd0;
        bus.choose    = 2'd0;
`ifdef PID_CONST_COMMIT_EN
        bus.commit    = 1'b0;
`endif
        exp_ki = INIT_KI;
        exp_kp = INIT_KP;
        exp_tv = INIT_TV;

        // reset state
        repeat (3) tick();
        chk("rst_ki", bus.k_i, INIT_KI);
        chk("rst_kp", bus.k_p, INIT_KP);
        chk("rst_tv", bus.target_v, INIT_TV);
        chk("rst_cur", bus.cur_val, 0);
        chk("rst_sat", bus.sat, 0);
        rst = 1'b0;
        tick();
        tick();
        chk("ki_ch0", field(bus.k_i, 0), 45);
        chk("tv_ch4", bus.target_v[64:52], 2048);
        chk("cur_after_rst", bus.cur_val, 45);

        // single 1-cycle inc on ch0 k_p
        bus.choose = 2'd1;
        repeat (3) tick();
        chk("cur_kp0_pre", bus.cur_val, 14);
        bus.inc_const = 1'b1;
        tick();
        bus.inc_const = 1'b0;
        chk("kp0_e0", field(bus.k_p, 0), 14);
        tick();
        chk("kp0_e1", field(bus.k_p, 0), 15);
        chk("cur_e1", bus.cur_val, 14);
        chk("sat_e1", bus.sat, 0);
        tick();
        chk("cur_e2", bus.cur_val, 15);
        repeat (6) tick();
        chk("kp0_after", field(bus.k_p, 0), 15);
        chk("sat_after", bus.sat, 0);
        exp_kp[0 +: WIDTH] = 13'd15;
        chk("kp_all", bus.k_p, exp_kp);

        // hold inc 20 cycles on ch2 target_v, checked every cycle
        bus.choose_c = 3'd2;
        bus.choose   = 2'd2;
        repeat (3) tick();
        bus.inc_const = 1'b1;
        for (int i = 0; i < 23; i++) begin
            tick();
            if (i == 19) bus.inc_const = 1'b0;
            last = (i - 1 < 19) ? i - 1 : 19;
            chk("tv2_hold", field(bus.target_v, 2), 2158 + hold_sum(last));
        end
        chk("tv2_final", field(bus.target_v, 2), 2242);
        chk("cur_tv2", bus.cur_val, 2242);
        exp_tv[2*WIDTH +: WIDTH] = 13'd2242;
        chk("tv_all", bus.target_v, exp_tv);

        // ch1 k_i up to 8180 by a long hold, then to 8190 by single presses
        bus.choose_c = 3'd1;
        bus.choose   = 2'd0;
        repeat (3) tick();
        bus.inc_const = 1'b1;
        repeat (1027) tick();
        bus.inc_const = 1'b0;
        repeat (3) tick();
        chk("ki1_long", field(bus.k_i, 1), 32 + hold_sum(1026));
        chk("ki1_8180", field(bus.k_i, 1), 8180);
        for (int p = 0; p < 10; p++) begin
            bus.inc_const = 1'b1;
            tick();
            bus.inc_const = 1'b0;
            repeat (3) tick();
        end
        chk("ki1_8190", field(bus.k_i, 1), 8190);
        bus.inc_const = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 8) bus.inc_const = 1'b0;
            chk("sat_hi", bus.sat, (i == 5 || i == 7 || i == 9) ? 1 : 0);
            chk("ki1_top", field(bus.k_i, 1), (i >= 1) ? 8191 : 8190);
        end
        exp_ki[1*WIDTH +: WIDTH] = 13'd8191;

        // dec ch3 k_i from 4 down to 0, then clipped steps
        bus.choose_c = 3'd3;
        repeat (3) tick();
        bus.dec_const = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (i == 10) bus.dec_const = 1'b0;
            last = (i - 1 < 10) ? i - 1 : 10;
            ev = 4 - hold_sum(last);
            if (ev < 0) ev = 0;
            chk("ki3_dec", field(bus.k_i, 3), ev);
            chk("sat_lo", bus.sat, (i == 11) ? 1 : 0);
        end
        bus.dec_const = 1'b1;
        tick();
        bus.dec_const = 1'b0;
        tick();
        chk("ki3_zero", field(bus.k_i, 3), 0);
        chk("sat_zero", bus.sat, 1);
        tick();
        chk("sat_zero_end", bus.sat, 0);
        exp_ki[3*WIDTH +: WIDTH] = 13'd0;
        chk("ki_all", bus.k_i, exp_ki);

        // reversal mid-repeat on ch4 target_v (choose=3)
        bus.choose_c = 3'd4;
        bus.choose   = 2'd3;
        repeat (3) tick();
        bus.inc_const = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 6)  bus.dec_const = 1'b1;
            if (i == 12) bus.dec_const = 1'b0;
            if (i == 16) bus.inc_const = 1'b0;
            chk("tv4_rev", field(bus.target_v, 4),
                2048 + ((i >= 1) ? 1 : 0) + ((i >= 5) ? 1 : 0) + ((i >= 7) ? 1 : 0));
        end
        bus.inc_const = 1'b1;
        tick();
        bus.inc_const = 1'b0;
        tick();
        tick();
        chk("tv4_repress", field(bus.target_v, 4), 2052);
        chk("cur_tv4", bus.cur_val, 2052);
        exp_tv[4*WIDTH +: WIDTH] = 13'd2052;

        // out-of-range channel: steps consumed, nothing changes
        bus.choose_c = 3'd6;
        bus.choose   = 2'd0;
        repeat (3) tick();
        chk("cur_ch6", bus.cur_val, 0);
        bus.inc_const = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("ki_ch6", bus.k_i, exp_ki);
            chk("sat_ch6", bus.sat, 0);
        end
        bus.inc_const = 1'b0;
        repeat (3) tick();
        chk("kp_ch6", bus.k_p, exp_kp);
        chk("tv_ch6", bus.target_v, exp_tv);
        chk("cur_ch6_end", bus.cur_val, 0);

        // reset mid-repeat with the button still held
        bus.choose_c = 3'd0;
        repeat (3) tick();
        bus.inc_const = 1'b1;
        repeat (8) tick();
        chk("ki0_prerst", field(bus.k_i, 0), 48);
        rst = 1'b1;
        repeat (2) tick();
        chk("rst2_ki", bus.k_i, INIT_KI);
        chk("rst2_kp", bus.k_p, INIT_KP);
        chk("rst2_tv", bus.target_v, INIT_TV);
        chk("rst2_cur", bus.cur_val, 0);
        rst = 1'b0;
        repeat (10) tick();
        chk("held_ki", bus.k_i, INIT_KI);
        chk("held_cur", bus.cur_val, 45);
        bus.inc_const = 1'b0;
        repeat (2) tick();
        bus.inc_const = 1'b1;
        tick();
        bus.inc_const = 1'b0;
        tick();
        chk("ki0_repress", field(bus.k_i, 0), 46);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
